// File: rtl/display_scan.sv
// Scan driver for the 8x8 bicolour matrix and 8-digit 7-segment display.
// Frames are snapshotted at the start of each scan frame, and every step begins with a blanking window.
module display_scan #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 2000
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic [63:0] matrix_r,
  input  logic [63:0] matrix_g,
  input  logic [31:0] seg_data,
  input  logic [7:0]  seg_on,
  output logic [7:0]  row_n,
  output logic [7:0]  col_r,
  output logic [7:0]  col_g,
  output logic [7:0]  seg_sel_n,
  output logic [7:0]  seg_code_n,
  output logic        frame_start
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

  logic [CW-1:0] div_cnt;
  logic [2:0]    scan_idx;
  logic [63:0]   shadow_r, shadow_g;
  logic [31:0]   shadow_seg;
  logic [7:0]    shadow_on;

  logic          frame_top;
  logic [7:0]    row_bits_r, row_bits_g;
  logic [3:0]    digit;
  logic [7:0]    row_nxt, col_r_nxt, col_g_nxt, sel_nxt, code_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] d);
    case (d)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  assign frame_top = (div_cnt == '0) && (scan_idx == 3'd0);

  // Scan counters plus the frame snapshot; the snapshot only moves at the frame boundary to avoid tearing.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      scan_idx   <= 3'd0;
      shadow_r   <= '0;
      shadow_g   <= '0;
      shadow_seg <= '0;
      shadow_on  <= '0;
    end else begin
      if (div_cnt == DIV_LAST) begin
        div_cnt  <= '0;
        scan_idx <= scan_idx + 3'd1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (frame_top) begin
        shadow_r   <= matrix_r;
        shadow_g   <= matrix_g;
        shadow_seg <= seg_data;
        shadow_on  <= seg_on;
      end
    end
  end

  // Row i lives in the byte whose MSB is the leftmost column, so the byte is bit-reversed onto col[].
  assign row_bits_r = 8'(shadow_r >> (6'd56 - {scan_idx, 3'b000}));
  assign row_bits_g = 8'(shadow_g >> (6'd56 - {scan_idx, 3'b000}));
  assign digit      = 4'(shadow_seg >> (5'd28 - {scan_idx, 2'b00}));

  always_comb begin
    row_nxt   = 8'hFF;
    col_r_nxt = 8'h00;
    col_g_nxt = 8'h00;
    sel_nxt   = 8'hFF;
    code_nxt  = 8'hFF;
    if (div_cnt >= BLANK_END) begin
      row_nxt = ~(8'd1 << scan_idx);
      for (int k = 0; k < 8; k++) begin
        col_r_nxt[k] = row_bits_r[7-k];
        col_g_nxt[k] = row_bits_g[7-k];
      end
      if (shadow_on[3'd7 - scan_idx]) begin
        sel_nxt  = ~(8'd1 << scan_idx);
        code_nxt = ~{1'b0, hex7(digit)};
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      row_n       <= 8'hFF;
      col_r       <= 8'h00;
      col_g       <= 8'h00;
      seg_sel_n   <= 8'hFF;
      seg_code_n  <= 8'hFF;
      frame_start <= 1'b0;
    end else begin
      row_n       <= row_nxt;
      col_r       <= col_r_nxt;
      col_g       <= col_g_nxt;
      seg_sel_n   <= sel_nxt;
      seg_code_n  <= code_nxt;
      frame_start <= frame_top;
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with SCAN_DIV=4, BLANK_CYC=1; expected outputs are queued per
// output cycle and a negedge monitor pops and compares them.
module tb_display_scan;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic [63:0] matrix_r, matrix_g;
  logic [31:0] seg_data;
  logic [7:0]  seg_on;
  logic [7:0]  row_n, col_r, col_g, seg_sel_n, seg_code_n;
  logic        frame_start;

  typedef struct packed {
    logic [15:0] cyc;
    logic        fs;
    logic [7:0]  row;
    logic [7:0]  cr;
    logic [7:0]  cg;
    logic [7:0]  sel;
    logic [7:0]  code;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] hex7_tab [16];

  display_scan #(.SCAN_DIV(4), .BLANK_CYC(1)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .matrix_r(matrix_r), .matrix_g(matrix_g), .seg_data(seg_data), .seg_on(seg_on),
    .row_n(row_n), .col_r(col_r), .col_g(col_g),
    .seg_sel_n(seg_sel_n), .seg_code_n(seg_code_n), .frame_start(frame_start)
  );

  // clock / reset-relative cycle counter: cyc = n after the n-th edge following release
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got cyc=%0d", cyc);
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int c, input exp_t got, input exp_t exp);
    n_checks++;
    if (got[40:0] !== exp[40:0]) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got fs=%b row=%h cr=%h cg=%h sel=%h code=%h required fs=%b row=%h cr=%h cg=%h sel=%h code=%h",
               name, c, got.fs, got.row, got.cr, got.cg, got.sel, got.code,
               exp.fs, exp.row, exp.cr, exp.cg, exp.sel, exp.code);
    end
  endtask

  function automatic exp_t sample();
    exp_t s;
    s.cyc  = 16'(cyc);
    s.fs   = frame_start;
    s.row  = row_n;
    s.cr   = col_r;
    s.cg   = col_g;
    s.sel  = seg_sel_n;
    s.code = seg_code_n;
    return s;
  endfunction

  // scoreboard monitor
  always @(negedge sys_clk) begin
    if (rst_n && exp_q.size() > 0) begin
      if (int'(exp_q[0].cyc) == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        check("scan_out", cyc, sample(), e);
      end else if (int'(exp_q[0].cyc) < cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL missed_sample cyc=%0d required at cyc=%0d", cyc, e.cyc);
      end
    end
  end

  // driver tasks
  task automatic push(input int c, input logic fs, input logic [7:0] row, input logic [7:0] cr,
                      input logic [7:0] cg, input logic [7:0] sel, input logic [7:0] code);
    exp_t e;
    e.cyc = 16'(c); e.fs = fs; e.row = row; e.cr = cr; e.cg = cg; e.sel = sel; e.code = code;
    exp_q.push_back(e);
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge sys_clk);
  endtask

  task automatic set_inputs(input logic [63:0] r, input logic [63:0] g,
                            input logic [31:0] d, input logic [7:0] on);
    matrix_r = r; matrix_g = g; seg_data = d; seg_on = on;
  endtask

  initial begin
    hex7_tab = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    rst_n = 1'b0;
    set_inputs('0, '0, '0, '0);
    repeat (3) @(negedge sys_clk);

    // frame 0: all zero inputs
    push(1,  1'b1, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF);
    push(2,  1'b0, 8'hFE, 8'h00, 8'h00, 8'hFF, 8'hFF);
    push(3,  1'b0, 8'hFE, 8'h00, 8'h00, 8'hFF, 8'hFF);
    push(4,  1'b0, 8'hFE, 8'h00, 8'h00, 8'hFF, 8'hFF);
    push(5,  1'b0, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF);
    push(32, 1'b0, 8'h7F, 8'h00, 8'h00, 8'hFF, 8'hFF);
    rst_n = 1'b1;

    // frame 1: corner pixels, digit 2 shows '1'
    wait_until(32);
    set_inputs(64'h8000_0000_0000_0001, '0, 32'h0012_0000, 8'b0010_0000);
    push(33, 1'b1, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF);
    push(34, 1'b0, 8'hFE, 8'h01, 8'h00, 8'hFF, 8'hFF);
    push(42, 1'b0, 8'hFB, 8'h00, 8'h00, 8'hFB, 8'hF9);
    push(46, 1'b0, 8'hF7, 8'h00, 8'h00, 8'hFF, 8'hFF);
    push(50, 1'b0, 8'hEF, 8'h00, 8'h00, 8'hFF, 8'hFF);
    push(62, 1'b0, 8'h7F, 8'h80, 8'h00, 8'hFF, 8'hFF);

    // green goes all-ones during step 3; must stay hidden until frame 2
    wait_until(45);
    matrix_g = '1;

    wait_until(64);
    push(65, 1'b1, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF);
    push(66, 1'b0, 8'hFE, 8'h01, 8'hFF, 8'hFF, 8'hFF);
    push(74, 1'b0, 8'hFB, 8'h00, 8'hFF, 8'hFB, 8'hF9);

    // frames 3..18: sweep digit 0 over 0..F
    for (int d = 0; d < 16; d++) begin
      int f;
      f = 3 + d;
      wait_until(32 * f);
      set_inputs('0, '0, {4'(d), 28'h0}, 8'h80);
      push(32 * f + 2, 1'b0, 8'hFE, 8'h00, 8'h00, 8'hFE, ~hex7_tab[d]);
      push(32 * f + 6, 1'b0, 8'hFD, 8'h00, 8'h00, 8'hFF, 8'hFF);
    end

    // frame 19: digit 5 shows '8', then reset in mid-drive of step 5
    wait_until(608);
    set_inputs('0, '0, 32'h0000_0800, 8'h04);
    push(630, 1'b0, 8'hDF, 8'h00, 8'h00, 8'hDF, 8'h80);
    wait_until(630);
    #2 rst_n = 1'b0;
    #1 begin
      exp_t rv;
      rv = '0;
      rv.row = 8'hFF; rv.sel = 8'hFF; rv.code = 8'hFF;
      check("async_reset", cyc, sample(), rv);
    end

    set_inputs(64'h0100_0000_0000_0000, '0, 32'hA000_0000, 8'h80);
    push(1,  1'b1, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF);
    push(2,  1'b0, 8'hFE, 8'h80, 8'h00, 8'hFE, 8'h88);
    push(33, 1'b1, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF);
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
    wait_until(34);

    // final report
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain got %0d pending entries, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scan.md
Name: display_scan

Overview:
- Output stage for the bath-heater display. Sits directly downstream of the animation/mode controller.
- Takes the 64-bit red and green matrix frames, the 8-digit hex segment word, and the per-digit enables.
- Time-multiplexes them onto the 8x8 bicolour matrix row/column pins and the 8-digit 7-segment select/segment pins.
- Adds per-step ghost blanking and frame-coherent snapshotting.

Parameters:
- SCAN_DIV, 50000: sys_clk cycles per scan step (one matrix row plus one digit). Legal range is >= 2.
- BLANK_CYC, 2000: cycles at the start of each step during which all outputs are off. Legal range is 1 <= BLANK_CYC < SCAN_DIV.

Ports:
- sys_clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- matrix_r, in, 64: red frame. Bits [63-8i -: 8] are row i, row 0 at the top. The byte MSB is the leftmost column.
- matrix_g, in, 64: green frame, same layout as matrix_r.
- seg_data, in, 32: hex digits. Digit i = seg_data[31-4i -: 4], digit 0 is leftmost.
- seg_on, in, 8: digit enables. Digit i is enabled by seg_on[7-i].
- row_n, out, 8: matrix row drive, active-low. row_n[i] selects row i.
- col_r, out, 8: red column drive, active-high. col_r[k] = column k, k=0 is leftmost.
- col_g, out, 8: green column drive, same as col_r.
- seg_sel_n, out, 8: digit select, active-low. seg_sel_n[i] selects digit i.
- seg_code_n, out, 8: segments {dp,g,f,e,d,c,b,a}, active-low.
- frame_start, out, 1: one-cycle pulse at the start of each frame.

Behaviour:
- State:
  - div_cnt counts 0..SCAN_DIV-1 and wraps to 0.
  - scan_idx is 3 bits. It increments when div_cnt==SCAN_DIV-1 and wraps 7->0.
- Reset (async):
  - div_cnt=0, scan_idx=0, shadow registers=0.
  - row_n=8'hFF, col_r=col_g=8'h00, seg_sel_n=8'hFF, seg_code_n=8'hFF, frame_start=0.
- Snapshot:
  - When div_cnt==0 && scan_idx==0, shadow_r/shadow_g/shadow_seg/shadow_on load the live inputs.
  - Input changes in mid-frame never appear until the next frame. This prevents tearing.
  - The load also occurs on the first cycle after reset release.
- Output timing:
  - All outputs are registered and reflect the state (div_cnt, scan_idx, shadow) of the previous cycle. Latency is 1 cycle.
- Blank window (div_cnt < BLANK_CYC):
  - row_n=FF, col_r=col_g=00, seg_sel_n=FF, seg_code_n=FF.
- Drive window (div_cnt >= BLANK_CYC), with i = scan_idx:
  - row_n = ~(8'b1 << i).
  - col_r[k] = shadow_r[63-8i-k]. col_g is defined the same way from shadow_g.
  - If shadow_on[7-i]=1: seg_sel_n = ~(8'b1 << i) and seg_code_n = ~hex7(shadow_seg digit i), with dp off.
  - If shadow_on[7-i]=0: seg_sel_n=FF and seg_code_n=FF.
- hex7 encoding, {g..a}:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Overlap: a row and a digit are never selected during a blank cycle. Selects for step i and step i+1 are never simultaneously low.
- frame_start is 1 exactly on the output cycle that follows the state (div_cnt==0, scan_idx==0). Its period is 8*SCAN_DIV cycles.
- Reset asserted mid-step: all outputs return to their reset values immediately (asynchronously). After release the scan restarts at row 0 with a fresh snapshot.
- Red and green set on the same pixel drive both columns (mixed colour). No priority is applied.

Test Plan (bench uses SCAN_DIV=4, BLANK_CYC=1):
- Reset with inputs all zero, then release.
  - Cycle 1 after release: frame_start=1 and all outputs blank.
  - Cycles 2-4: row_n=FE, col_r=col_g=00, seg_sel_n=FF.
  - The frame_start period is 32 cycles.
- matrix_r=64'h8000_0000_0000_0001, matrix_g=0.
  - Step 0 drive: row_n=FE, col_r=01 (leftmost).
  - Step 7 drive: row_n=7F, col_r=80.
  - col_g=00 in all steps.
- seg_data=32'h0012_0000, seg_on=8'b0010_0000.
  - Step 2 drive: seg_sel_n=FB, seg_code_n=~8'h06=F9.
  - Step 3 drive: seg_sel_n=FF.
  - seg_sel_n=FF in every other step.
- Change matrix_g from 0 to all-ones during step 3.
  - col_g stays 00 for steps 3-7 of the current frame.
  - col_g becomes FF from step 0 of the next frame.
- Sweep seg_data over 0..F on digit 0 with seg_on=80. Each frame, seg_code_n equals ~hex7 for that digit per the table.
- Assert rst_n low in mid-drive of step 5.
  - Outputs go to reset values within the same cycle (async).
  - After release, the first driven row is row 0 (row_n=FE).
